// File: rtl/b01_serial_sched.sv
// b01_serial_sched
//   Bit-serial add scheduler shared by two requesters (A and B).
//   A round-robin arbiter grants one requester while idle. The granted
//   operand pair is streamed LSB-first through a one-bit carry adder, one
//   bit per clock. The reassembled sum is returned with the requester ID on
//   a valid/ready response port.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   req_a_valid  : requester A presents an operand pair
//   req_a_x/y    : requester A operands (WIDTH bits)
//   req_a_ready  : A accepted on this edge (combinational, IDLE only)
//   req_b_valid  : requester B presents an operand pair
//   req_b_x/y    : requester B operands (WIDTH bits)
//   req_b_ready  : B accepted on this edge (combinational, IDLE only)
//   rsp_valid    : result available, held until rsp_ready
//   rsp_ready    : consumer takes the result
//   rsp_id       : 0 = result for A, 1 = result for B
//   rsp_sum      : (x+y) mod 2^WIDTH
//   rsp_ovf      : carry out of the MSB
//   busy         : high in every state except IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; ready outputs may be asserted
// SHIFT | adding one bit per cycle, WIDTH cycles in total
// DONE  | response held on rsp_* until the consumer takes it

module b01_serial_sched #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a_valid,
    input  logic [WIDTH-1:0] req_a_x,
    input  logic [WIDTH-1:0] req_a_y,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [WIDTH-1:0] req_b_x,
    input  logic [WIDTH-1:0] req_b_y,
    output logic             req_b_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic             ptr;      // 0 = A has priority on a tie, 1 = B
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cur_id;

    logic             grant_a;
    logic             grant_b;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    // Ready is suppressed during reset so nothing can look accepted on an
    // edge where the FSM is being forced back to IDLE.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE && !reset) begin
            if (req_a_valid && req_b_valid) begin
                grant_a = !ptr;
                grant_b = ptr;
            end else begin
                grant_a = req_a_valid;
                grant_b = req_b_valid;
            end
        end
    end

    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;
    assign busy        = (state != IDLE);

    // One-bit full adder on the current LSBs.
    assign s_bit    = x_sh[0] ^ y_sh[0] ^ carry;
    assign c_next   = (x_sh[0] & y_sh[0]) | (x_sh[0] & carry) | (y_sh[0] & carry);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    assign sum_next = {s_bit, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            x_sh      <= '0;
            y_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            cur_id    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        x_sh   <= grant_b ? req_b_x : req_a_x;
                        y_sh   <= grant_b ? req_b_y : req_a_y;
                        cur_id <= grant_b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        // Priority moves to whoever was not just served.
                        ptr    <= grant_a;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    x_sh   <= x_sh >> 1;
                    y_sh   <= y_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= c_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        rsp_sum   <= sum_next;
                        rsp_ovf   <= c_next;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
